// File: rtl/osd_mam_mem_arbiter.sv
// osd_mam_mem_arbiter
//   Shares one MAM-style memory port (request / write-beat / read-beat streams)
//   between N_REQ requesters. Arbitration is round-robin. A grant covers one
//   whole transaction: the request beat plus every write or read data beat.
//   Data, address and strobes pass through as plain muxes on the granted index.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   in_req_*                      per-requester request channel (packed per index)
//   in_write_*                    per-requester write-beat channel
//   in_read_valid/ready           per-requester read-beat handshake
//   in_read_data                  read data, broadcast to all requesters
//   req_*, write_*, read_*        memory-side channels
//   grant_valid, grant_id         a transaction is owned, and by which requester
module osd_mam_mem_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             rst,

  input  logic [N_REQ-1:0]                 in_req_valid,
  output logic [N_REQ-1:0]                 in_req_ready,
  input  logic [N_REQ-1:0]                 in_req_rw,
  input  logic [N_REQ*ADDR_WIDTH-1:0]      in_req_addr,
  input  logic [N_REQ-1:0]                 in_req_burst,
  input  logic [N_REQ*14-1:0]              in_req_beats,

  input  logic [N_REQ-1:0]                 in_write_valid,
  output logic [N_REQ-1:0]                 in_write_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]      in_write_data,
  input  logic [N_REQ*DATA_WIDTH/8-1:0]    in_write_strb,

  output logic [N_REQ-1:0]                 in_read_valid,
  input  logic [N_REQ-1:0]                 in_read_ready,
  output logic [DATA_WIDTH-1:0]            in_read_data,

  output logic                             req_valid,
  input  logic                             req_ready,
  output logic                             req_rw,
  output logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             req_burst,
  output logic [13:0]                      req_beats,

  output logic                             write_valid,
  input  logic                             write_ready,
  output logic [DATA_WIDTH-1:0]            write_data,
  output logic [DATA_WIDTH/8-1:0]          write_strb,

  input  logic                             read_valid,
  output logic                             read_ready,
  input  logic [DATA_WIDTH-1:0]            read_data,

  output logic                             grant_valid,
  output logic [$clog2(N_REQ)-1:0]         grant_id
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WRITE,
    ST_READ
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [13:0]   cnt_q, cnt_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;

  // Round-robin search starting one past the previous owner, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      int unsigned   idx_full;
      logic [IW-1:0] idx;
      idx_full = (32'(last_q) + k) % N_REQ;
      idx      = IW'(idx_full);
      if (!pick_found && in_req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  // Data paths: plain muxes on the current grant.
  assign req_rw       = in_req_rw[grant_q];
  assign req_addr     = in_req_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign req_burst    = in_req_burst[grant_q];
  assign req_beats    = in_req_beats[grant_q*14 +: 14];
  assign write_data   = in_write_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign write_strb   = in_write_strb[grant_q*SW +: SW];
  assign in_read_data = read_data;

  assign grant_valid  = (state_q != ST_IDLE);
  assign grant_id     = grant_q;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    req_valid      = 1'b0;
    in_req_ready   = '0;
    write_valid    = 1'b0;
    in_write_ready = '0;
    in_read_valid  = '0;
    read_ready     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ST_REQ;
        end
      end

      // req_valid comes from state only, so in_req_valid never reaches it
      // combinationally; the owner is required to hold its request anyway.
      ST_REQ: begin
        req_valid             = 1'b1;
        in_req_ready[grant_q] = req_ready;
        if (req_ready) begin
          // A zero-length burst is one beat, not a 14-bit wrap.
          cnt_d   = (req_burst && (req_beats != '0)) ? req_beats : 14'd1;
          state_d = req_rw ? ST_WRITE : ST_READ;
        end
      end

      ST_WRITE: begin
        write_valid             = in_write_valid[grant_q];
        in_write_ready[grant_q] = write_ready;
        if (in_write_valid[grant_q] && write_ready) begin
          cnt_d = cnt_q - 14'd1;
          if (cnt_q == 14'd1) begin
            last_d  = grant_q;
            state_d = ST_IDLE;
          end
        end
      end

      ST_READ: begin
        in_read_valid[grant_q] = read_valid;
        read_ready             = in_read_ready[grant_q];
        if (read_valid && in_read_ready[grant_q]) begin
          cnt_d = cnt_q - 14'd1;
          if (cnt_q == 14'd1) begin
            last_d  = grant_q;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
